dm_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the byte-addressed data memory (`dm`). Port 0 (CPU load/store unit) and port 1 (debug/DMA loader) share the single memory through a three-state FSM with round-robin fairness. Each accepted request gets exactly one memory cycle and one response pulse. The block sits between the requesters and `dm`; it drives `dm`'s `DMWr`, `addr`, `din` and `DMType` inputs and captures `dout`.

---
 rtl/dm_arb_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 13 +
 rtl/dm_arbiter.sv | 140 ++++++++++++++
 tb/tb_dm_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared encodings for the data-memory arbiter: DMType codes, FSM states and
// the alignment rule used when DM_ARB_ALIGN_CHECK_EN is defined.
package dm_arb_pkg;

   localparam logic [2:0] DM_WORD   = 3'b000;
   localparam logic [2:0] DM_HALF   = 3'b001;
   localparam logic [2:0] DM_HALF_U = 3'b010;
   localparam logic [2:0] DM_BYTE   = 3'b011;
   localparam logic [2:0] DM_BYTE_U = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   // Halfwords need an even address, words a 4-byte aligned one.
   function automatic logic misaligned(input logic [2:0] dm_type, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      case (dm_type)
         DM_WORD:            bad = (addr_lo != 2'b00);
         DM_HALF, DM_HALF_U: bad = addr_lo[0];
         default:            bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not served last.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       win,
   output logic       any
);

   assign any = |req;
   assign win = (&req) ? ~last : req[1];

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter and one-access-per-three-cycle sequencer in front of dm.
// Optional misalignment trap: define DM_ARB_ALIGN_CHECK_EN.
//
//   state    | meaning
//   ST_IDLE  | arbitrate; latch the winner's access when any port requests
//   ST_ISSUE | drive dm for one cycle, gnt to winner, capture dm_dout
//   ST_RESP  | rvalid (and err) to winner; never arbitrates
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [2:0]        m0_type,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [2:0]        m1_type,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic              dm_wr,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_din,
   output logic [2:0]        dm_type,
   input  logic [DATA_W-1:0] dm_dout
);

   state_e            state_q;
   logic              last_q;
   logic              port_q;
   logic              we_q;
   logic              err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [2:0]        type_q;

   logic              win;
   logic              any;
   logic              we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic [2:0]        type_d;
   logic              err_d;
   logic              issue;
   logic              resp;

   rr_arb2 u_rr_arb2 (
      .req  ({m1_req, m0_req}),
      .last (last_q),
      .win  (win),
      .any  (any)
   );

   always_comb begin
      we_d    = m0_we;
      addr_d  = m0_addr;
      wdata_d = m0_wdata;
      type_d  = m0_type;
      if (win) begin
         we_d    = m1_we;
         addr_d  = m1_addr;
         wdata_d = m1_wdata;
         type_d  = m1_type;
      end
   end

`ifdef DM_ARB_ALIGN_CHECK_EN
   assign err_d = misaligned(type_d, addr_d[1:0]);
`else
   assign err_d = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         port_q  <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         type_q  <= DM_WORD;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any) begin
                  port_q  <= win;
                  last_q  <= win;
                  we_q    <= we_d;
                  err_q   <= err_d;
                  addr_q  <= addr_d;
                  wdata_q <= wdata_d;
                  type_q  <= type_d;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // A trapped access reports zero rather than whatever dm returns.
               rdata_q <= err_q ? '0 : dm_dout;
               state_q <= ST_RESP;
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign issue = (state_q == ST_ISSUE);
   assign resp  = (state_q == ST_RESP);

   assign m0_gnt    = issue & ~port_q;
   assign m1_gnt    = issue &  port_q;
   assign m0_rvalid = resp  & ~port_q;
   assign m1_rvalid = resp  &  port_q;
   assign m0_err    = resp  & ~port_q & err_q;
   assign m1_err    = resp  &  port_q & err_q;
   assign m0_rdata  = rdata_q;
   assign m1_rdata  = rdata_q;

   assign dm_wr   = issue & we_q & ~err_q;
   assign dm_addr = addr_q;
   assign dm_din  = wdata_q;
   assign dm_type = type_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: behavioural dm stand-in, transaction-level reference
// model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [5:0]  m0_addr = '0;
   logic [31:0] m0_wdata = '0;
   logic [2:0]  m0_type = '0;
   logic        m1_req = 1'b0, m1_we = 1'b0;
   logic [5:0]  m1_addr = '0;
   logic [31:0] m1_wdata = '0;
   logic [2:0]  m1_type = '0;
   logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        dm_wr;
   logic [5:0]  dm_addr;
   logic [31:0] dm_din, dm_dout;
   logic [2:0]  dm_type;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   dm_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_type(m0_type),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_type(m1_type),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din), .dm_type(dm_type), .dm_dout(dm_dout)
   );

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      else n_pass++;
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_total++;
      if (act !== exp) $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] ext(input logic [7:0] b0, b1, b2, b3, input logic [2:0] t);
      case (t)
         3'b001:  return {{16{b1[7]}}, b1, b0};
         3'b010:  return {16'h0000, b1, b0};
         3'b011:  return {{24{b0[7]}}, b0};
         3'b100:  return {24'h000000, b0};
         default: return {b3, b2, b1, b0};
      endcase
   endfunction

   function automatic int wr_bytes(input logic [2:0] t);
      case (t)
         3'b000:  return 4;
         3'b001:  return 2;
         3'b011:  return 1;
         default: return 0;
      endcase
   endfunction

   // dm stand-in: little-endian bytes, write on falling edge, combinational read
   logic [7:0] mem [64];
   logic [5:0] ra1, ra2, ra3;
   always_comb begin
      ra1 = dm_addr + 6'd1;
      ra2 = dm_addr + 6'd2;
      ra3 = dm_addr + 6'd3;
      dm_dout = ext(mem[dm_addr], mem[ra1], mem[ra2], mem[ra3], dm_type);
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      forever begin
         @(negedge clk);
         if (dm_wr === 1'b1)
            for (int i = 0; i < wr_bytes(dm_type); i++) mem[dm_addr + 6'(i)] = dm_din[8*i +: 8];
      end
   end

   // Reference model: what each requester should see, tracked per accepted access
   logic [7:0]  ref_mem [64];
   int          cyc = 0;
   int          acc_cyc = -100;
   int          next_arb = 0;
   bit          model_on = 1'b0;
   bit          m_last = 1'b1;
   bit          a_port, a_we, a_mis, a_known;
   logic [31:0] a_rdata;
   logic [5:0]  h_addr;
   logic [31:0] h_din;
   logic [2:0]  h_type;
   logic [31:0] e_rdata;
   bit          e_known;

   function automatic bit bad_align(input logic [2:0] t, input logic [5:0] a);
`ifdef DM_ARB_ALIGN_CHECK_EN
      if (t == 3'b000) return a[1:0] != 2'b00;
      if (t == 3'b001 || t == 3'b010) return a[0];
      return 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   initial begin
      bit p;
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            model_on = 1'b1;
            acc_cyc  = -100;
            next_arb = cyc + 1;
            m_last   = 1'b1;
            h_addr = '0; h_din = '0; h_type = '0;
            e_rdata = '0; e_known = 1'b1;
         end else if (model_on) begin
            if (acc_cyc == cyc - 1) begin
               e_rdata = a_rdata;
               e_known = a_known;
            end
            if (cyc >= next_arb && (m0_req || m1_req)) begin
               if (m0_req && !m1_req)      p = 1'b0;
               else if (m1_req && !m0_req) p = 1'b1;
               else                        p = (m_last == 1'b0);
               m_last = p;
               a_port = p;
               a_we   = p ? m1_we    : m0_we;
               h_addr = p ? m1_addr  : m0_addr;
               h_din  = p ? m1_wdata : m0_wdata;
               h_type = p ? m1_type  : m0_type;
               a_mis  = bad_align(h_type, h_addr);
               if (a_we && !a_mis)
                  for (int i = 0; i < wr_bytes(h_type); i++) ref_mem[h_addr + 6'(i)] = h_din[8*i +: 8];
               a_rdata = a_mis ? 32'h0 : ext(ref_mem[h_addr], ref_mem[h_addr + 6'd1],
                                             ref_mem[h_addr + 6'd2], ref_mem[h_addr + 6'd3], h_type);
               a_known = a_mis || !a_we;
               acc_cyc  = cyc;
               next_arb = cyc + 3;
            end
         end
      end
   end

   initial begin
      bit iss, rsp;
      forever begin
         @(negedge clk);
         if (model_on) begin
            iss = (acc_cyc == cyc);
            rsp = (acc_cyc == cyc - 1);
            chk1("m0_gnt", m0_gnt, iss && !a_port);
            chk1("m1_gnt", m1_gnt, iss && a_port);
            chk1("m0_rvalid", m0_rvalid, rsp && !a_port);
            chk1("m1_rvalid", m1_rvalid, rsp && a_port);
            chk1("m0_err", m0_err, rsp && !a_port && a_mis);
            chk1("m1_err", m1_err, rsp && a_port && a_mis);
            chk1("dm_wr", dm_wr, iss && a_we && !a_mis);
            chk32("dm_addr", {26'h0, dm_addr}, {26'h0, h_addr});
            chk32("dm_din", dm_din, h_din);
            chk32("dm_type", {29'h0, dm_type}, {29'h0, h_type});
            if (e_known) begin
               chk32("m0_rdata", m0_rdata, e_rdata);
               chk32("m1_rdata", m1_rdata, e_rdata);
            end
         end
      end
   end

   task automatic drive(input bit p, input bit r, input bit we, input logic [5:0] a,
                        input logic [31:0] d, input logic [2:0] t);
      if (p) begin m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d; m1_type = t; end
      else   begin m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d; m0_type = t; end
   endtask

   task automatic do_req(input bit p, input bit we, input logic [5:0] a, input logic [31:0] d,
                         input logic [2:0] t, output logic [31:0] rd, output logic er,
                         output int lat_g, output int lat_r);
      int n;
      drive(p, 1'b1, we, a, d, t);
      n = 0;
      do begin @(posedge clk); #2; n++; end while (!(p ? m1_gnt : m0_gnt) && n < 20);
      lat_g = n;
      chk1("gnt_seen", p ? m1_gnt : m0_gnt, 1'b1);
      if (p) m1_req = 1'b0; else m0_req = 1'b0;
      n = 0;
      do begin @(posedge clk); #2; n++; end while (!(p ? m1_rvalid : m0_rvalid) && n < 20);
      lat_r = n;
      chk1("rvalid_seen", p ? m1_rvalid : m0_rvalid, 1'b1);
      rd = p ? m1_rdata : m0_rdata;
      er = p ? m1_err : m0_err;
   endtask

   task automatic preload(input logic [5:0] a, input logic [31:0] d);
      for (int i = 0; i < 4; i++) begin
         mem[a + 6'(i)]     = d[8*i +: 8];
         ref_mem[a + 6'(i)] = d[8*i +: 8];
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lg, lr, n, spacing_ok;
      int          gp[$];
      int          gc[$];

      do_reset();
      chk32("reset_m0_rdata", m0_rdata, 32'h0);
      chk32("reset_dm_addr", {26'h0, dm_addr}, 32'h0);
      chk1("reset_dm_wr", dm_wr, 1'b0);
      rst = 1'b0;

      preload(6'd4, 32'h11223344);
      do_req(1'b0, 1'b0, 6'd4, 32'h0, 3'b000, rd, er, lg, lr);
      chk32("word_load_p0", rd, 32'h11223344);
      chk32("gnt_latency", lg, 1);
      chk32("rvalid_after_gnt", lr, 1);

      do_req(1'b0, 1'b1, 6'd9, 32'h000000F0, 3'b011, rd, er, lg, lr);
      do_req(1'b1, 1'b0, 6'd9, 32'h0, 3'b011, rd, er, lg, lr);
      chk32("byte_load_signed_p1", rd, 32'hFFFFFFF0);
      do_req(1'b1, 1'b0, 6'd9, 32'h0, 3'b100, rd, er, lg, lr);
      chk32("byte_load_unsigned_p1", rd, 32'h000000F0);
      do_req(1'b1, 1'b1, 6'd12, 32'h00008001, 3'b001, rd, er, lg, lr);
      do_req(1'b0, 1'b0, 6'd12, 32'h0, 3'b001, rd, er, lg, lr);
      chk32("half_load_signed", rd, 32'hFFFF8001);
      do_req(1'b0, 1'b0, 6'd12, 32'h0, 3'b010, rd, er, lg, lr);
      chk32("half_load_unsigned", rd, 32'h00008001);

      // contention from reset: both ports hold req
      do_reset();
      rst = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 6'd4, 32'h0, 3'b000);
      drive(1'b1, 1'b1, 1'b0, 6'd9, 32'h0, 3'b011);
      for (int i = 1; i <= 14; i++) begin
         @(posedge clk); #2;
         if (m0_gnt) begin gp.push_back(0); gc.push_back(i); end
         if (m1_gnt) begin gp.push_back(1); gc.push_back(i); end
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      chk1("contention_grant_count", gp.size() >= 4, 1'b1);
      if (gp.size() >= 4) begin
         chk32("contention_order", {gp[0][7:0], gp[1][7:0], gp[2][7:0], gp[3][7:0]}, 32'h00010001);
         spacing_ok = 1;
         for (int i = 1; i < 4; i++) if (gc[i] - gc[i-1] != 3) spacing_ok = 0;
         chk32("contention_spacing", spacing_ok, 1);
      end
      repeat (4) @(posedge clk);
      #2;

      // reset while a store is in ISSUE
      drive(1'b0, 1'b1, 1'b1, 6'd0, 32'hA5A5A5A5, 3'b000);
      n = 0;
      do begin @(posedge clk); #2; n++; end while (!m0_gnt && n < 20);
      chk1("rst_issue_gnt", m0_gnt, 1'b1);
      rst = 1'b1;
      m0_req = 1'b0;
      @(posedge clk); #2;
      chk1("rst_issue_no_rvalid", m0_rvalid, 1'b0);
      chk32("rst_issue_dm_addr", {26'h0, dm_addr}, 32'h0);
      chk32("rst_issue_rdata", m0_rdata, 32'h0);
      chk32("rst_issue_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'hA5A5A5A5);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;

      // misaligned word store at addr 2, then read back the word at 4
      do_req(1'b0, 1'b1, 6'd2, 32'hDEADBEEF, 3'b000, rd, er, lg, lr);
`ifdef DM_ARB_ALIGN_CHECK_EN
      chk1("misaligned_err", er, 1'b1);
      chk32("misaligned_rdata", rd, 32'h0);
      chk32("misaligned_mem", {mem[5], mem[4], mem[3], mem[2]}, 32'h3344A5A5);
      do_req(1'b0, 1'b0, 6'd4, 32'h0, 3'b000, rd, er, lg, lr);
      chk32("after_misaligned_load", rd, 32'h11223344);
`else
      chk1("misaligned_err", er, 1'b0);
      chk32("misaligned_mem", {mem[5], mem[4], mem[3], mem[2]}, 32'hDEADBEEF);
      do_req(1'b0, 1'b0, 6'd4, 32'h0, 3'b000, rd, er, lg, lr);
      chk32("after_misaligned_load", rd, 32'h1122DEAD);
`endif

      repeat (3) @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
